if_stim_seq: RTL and testbench
==============================

Name: if_stim_seq

Overview:
- Sequential stimulus and response collector for the IfEnt compare/arithmetic block.
- Drives operand pairs A/B into IfEnt and samples XOUT after a settle window.
- Folds the sampled results into a rotating signature and counts the compare class of each pair.
- Sits on the bench/BIST side of IfEnt: IfEnt consumes the operands, this block produces them and collects the results.

Parameters:
NBITS, 8, operand/result width (A, B, XOUT, SIG)
CNTBITS, 16, width of COUNT and class counters
SETTLE, 1, cycles A/B are held before XOUT is sampled (>=1)

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
START  in  1  begin a run (sampled only in IDLE)
A_SEED  in  NBITS  first A operand
B_SEED  in  NBITS  first B operand
A_STEP  in  NBITS  per-pair A increment
B_STEP  in  NBITS  per-pair B increment
COUNT  in  CNTBITS  number of pairs in the run
XOUT  in  NBITS  result from IfEnt (combinational from A/B)
A  out  NBITS  operand to IfEnt
B  out  NBITS  operand to IfEnt
BUSY  out  1  high from the cycle after START is accepted until DONE
DONE  out  1  one-cycle end-of-run pulse
SIG  out  NBITS  result signature
N_GT  out  CNTBITS  pairs with A>B
N_LT  out  CNTBITS  pairs with A<B
N_EQ  out  CNTBITS  pairs with A==B

Behaviour:
- One clock domain (CLK). Reset is synchronous, active-high (RST).
- Reset: state IDLE. A, B, SIG, N_GT, N_LT, N_EQ = 0. BUSY = 0, DONE = 0.
- RST mid-run aborts immediately to the reset state. No DONE pulse is produced.
- States:
  - IDLE: START=1 latches seeds, steps and COUNT. SIG and all counters clear to 0. A=A_SEED, B=B_SEED.
    - COUNT==0 -> FINISH.
    - Otherwise -> DRIVE, with the settle counter loaded with SETTLE-1.
  - DRIVE: holds A/B. Stays while the settle counter is nonzero, decrementing each cycle. Then -> SAMPLE.
  - SAMPLE: captures XOUT for the current A/B.
    - SIG <= {SIG[NBITS-2:0], SIG[NBITS-1]} ^ XOUT (rotate left by 1, then XOR).
    - Exactly one of N_GT/N_LT/N_EQ increments, by unsigned compare of the current A and B.
    - Counters saturate at all-ones.
    - Remaining count decrements. If it was 1 -> FINISH.
    - Otherwise A <= A+A_STEP, B <= B+B_STEP, both mod 2^NBITS (wrap, no carry out), and -> DRIVE with the settle counter reloaded.
  - FINISH: DONE=1 for this cycle only. -> IDLE.
- BUSY = 1 in DRIVE, SAMPLE and FINISH.
- START while not in IDLE is ignored. START held high in IDLE after FINISH begins a new run, clearing SIG and the counters.
- Latency: START accepted at cycle 0 -> DONE high at cycle 1 + COUNT*(SETTLE+1). For COUNT==0, DONE is high at cycle 1.
- A, B, SIG and the counters hold their final values after DONE until the next accepted START or RST.
- A/B change only on SAMPLE->DRIVE transitions. They are stable for SETTLE+1 cycles per pair, and XOUT is sampled on the last of those cycles.
- Seed/step inputs changing mid-run have no effect (latched copies are used).

Test Plan:
- SETTLE=1, A_SEED=5, B_SEED=3, steps 0, COUNT=1, XOUT=A+B stub, START at cycle 0 -> DONE high only at cycle 3, SIG=0x08, N_GT=1, N_LT=0, N_EQ=0, BUSY cycles 1-3.
- A_SEED=0, B_SEED=0, A_STEP=1, B_STEP=255, COUNT=4 -> A/B sequence (0,0),(1,255),(2,254),(3,253); N_EQ=1, N_LT=3, N_GT=0; DONE at cycle 9.
- XOUT stub constant 0x01, COUNT=3 -> SIG=0x07.
- COUNT=0 -> DONE at cycle 1, SIG and counters 0, A=A_SEED, B=B_SEED.
- START pulsed at cycle 2 of a COUNT=4 run (A_STEP=1, B_STEP=0) -> ignored, run completes unchanged.
- RST asserted at cycle 4 of a COUNT=4 run -> next cycle IDLE with all outputs 0 and no DONE.
- SETTLE=3 with XOUT wired to real IfEnt, COUNT=2, A_SEED=9, B_SEED=9, steps 0 -> each pair held 4 cycles, N_EQ=2, DONE at cycle 9.

Source files
------------

// File: rtl/if_stim_seq.sv
// if_stim_seq: drives A/B operand pairs into IfEnt, samples XOUT, builds a signature and compare-class counts
module if_stim_seq #(
    parameter int NBITS   = 8,
    parameter int CNTBITS = 16,
    parameter int SETTLE  = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [NBITS-1:0]   A_SEED,
    input  logic [NBITS-1:0]   B_SEED,
    input  logic [NBITS-1:0]   A_STEP,
    input  logic [NBITS-1:0]   B_STEP,
    input  logic [CNTBITS-1:0] COUNT,
    input  logic [NBITS-1:0]   XOUT,
    output logic [NBITS-1:0]   A,
    output logic [NBITS-1:0]   B,
    output logic               BUSY,
    output logic               DONE,
    output logic [NBITS-1:0]   SIG,
    output logic [CNTBITS-1:0] N_GT,
    output logic [CNTBITS-1:0] N_LT,
    output logic [CNTBITS-1:0] N_EQ
);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;
    state_t             state;
    logic [NBITS-1:0]   a_step, b_step;
    logic [CNTBITS-1:0] rem;
    logic [SW-1:0]      settle;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            A      <= '0;
            B      <= '0;
            SIG    <= '0;
            N_GT   <= '0;
            N_LT   <= '0;
            N_EQ   <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            a_step <= '0;
            b_step <= '0;
            rem    <= '0;
            settle <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: if (START) begin
                    a_step <= A_STEP;
                    b_step <= B_STEP;
                    rem    <= COUNT;
                    settle <= SW'(SETTLE - 1);
                    A      <= A_SEED;
                    B      <= B_SEED;
                    SIG    <= '0;
                    N_GT   <= '0;
                    N_LT   <= '0;
                    N_EQ   <= '0;
                    BUSY   <= 1'b1;
                    DONE   <= COUNT == '0;
                    state  <= COUNT == '0 ? FINISH : DRIVE;
                end
                DRIVE: begin
                    settle <= settle != '0 ? settle - 1'b1 : settle;
                    state  <= settle != '0 ? DRIVE : SAMPLE;
                end
                SAMPLE: begin
                    SIG  <= {SIG[NBITS-2:0], SIG[NBITS-1]} ^ XOUT;
                    // increments stop at all-ones so long runs saturate instead of wrapping
                    N_GT <= N_GT + CNTBITS'(A > B && N_GT != '1);
                    N_LT <= N_LT + CNTBITS'(A < B && N_LT != '1);
                    N_EQ <= N_EQ + CNTBITS'(A == B && N_EQ != '1);
                    rem  <= rem - 1'b1;
                    if (rem == CNTBITS'(1)) begin
                        DONE  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        A      <= A + a_step;
                        B      <= B + b_step;
                        settle <= SW'(SETTLE - 1);
                        state  <= DRIVE;
                    end
                end
                FINISH: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_stim_seq.sv
// tb_if_stim_seq: randomized and directed runs of if_stim_seq (SETTLE=1 and SETTLE=3) against a pair-list reference model
module tb_if_stim_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start [2];
    logic [7:0]  a_seed = '0, b_seed = '0, a_step = '0, b_step = '0;
    logic [15:0] count = '0;
    logic [7:0]  xo [2], ao [2], bo [2], sig [2];
    logic        busy [2], done [2];
    logic [15:0] ngt [2], nlt [2], neq [2];
    int          mode [2];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    // operand-to-result stand-ins for IfEnt: sum, constant one, difference
    function automatic logic [7:0] xf(input int m, input logic [7:0] a, input logic [7:0] b);
        return m == 0 ? 8'(a + b) : m == 1 ? 8'h01 : 8'(a - b);
    endfunction

    always_comb xo[0] = xf(mode[0], ao[0], bo[0]);
    always_comb xo[1] = xf(mode[1], ao[1], bo[1]);

    if_stim_seq #(.NBITS(8), .CNTBITS(16), .SETTLE(1)) dut0 (
        .CLK(clk), .RST(rst), .START(start[0]), .A_SEED(a_seed), .B_SEED(b_seed),
        .A_STEP(a_step), .B_STEP(b_step), .COUNT(count), .XOUT(xo[0]), .A(ao[0]), .B(bo[0]),
        .BUSY(busy[0]), .DONE(done[0]), .SIG(sig[0]), .N_GT(ngt[0]), .N_LT(nlt[0]), .N_EQ(neq[0]));

    if_stim_seq #(.NBITS(8), .CNTBITS(16), .SETTLE(3)) dut1 (
        .CLK(clk), .RST(rst), .START(start[1]), .A_SEED(a_seed), .B_SEED(b_seed),
        .A_STEP(a_step), .B_STEP(b_step), .COUNT(count), .XOUT(xo[1]), .A(ao[1]), .B(bo[1]),
        .BUSY(busy[1]), .DONE(done[1]), .SIG(sig[1]), .N_GT(ngt[1]), .N_LT(nlt[1]), .N_EQ(neq[1]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, " A"}, 32'(ao[d]), 0);
        chk({tag, " B"}, 32'(bo[d]), 0);
        chk({tag, " SIG"}, 32'(sig[d]), 0);
        chk({tag, " N_GT"}, 32'(ngt[d]), 0);
        chk({tag, " N_LT"}, 32'(nlt[d]), 0);
        chk({tag, " N_EQ"}, 32'(neq[d]), 0);
        chk({tag, " BUSY"}, 32'(busy[d]), 0);
        chk({tag, " DONE"}, 32'(done[d]), 0);
    endtask

    // one full run on instance d; the model lists the pairs k*step+seed and folds them directly
    task automatic run(input int d, input logic [7:0] as, input logic [7:0] bs,
                       input logic [7:0] ast, input logic [7:0] bst, input int n, input int m,
                       input bit poke);
        int per = d == 1 ? 4 : 2;
        int done_c = 1 + n * per;
        logic [7:0] es = '0, pa, pb;
        int gt = 0, lt = 0, eq = 0, k;
        for (int i = 0; i < n; i++) begin
            pa = 8'(as + i * ast);
            pb = 8'(bs + i * bst);
            es = {es[6:0], es[7]} ^ xf(m, pa, pb);
            if (pa > pb) gt++; else if (pa < pb) lt++; else eq++;
        end
        mode[d] = m;
        a_seed = as; b_seed = bs; a_step = ast; b_step = bst; count = 16'(n);
        start[d] = 1'b1;
        for (int c = 1; c <= done_c + 1; c++) begin
            tick();
            start[d] = poke && c == 2;
            a_seed = 8'($urandom); b_seed = 8'($urandom);
            a_step = 8'($urandom); b_step = 8'($urandom);
            count = 16'($urandom_range(0, 9));
            k = n == 0 ? 0 : ((c - 1) / per > n - 1 ? n - 1 : (c - 1) / per);
            chk($sformatf("d%0d c%0d BUSY", d, c), 32'(busy[d]), 32'(c <= done_c));
            chk($sformatf("d%0d c%0d DONE", d, c), 32'(done[d]), 32'(c == done_c));
            chk($sformatf("d%0d c%0d A", d, c), 32'(ao[d]), 32'(8'(as + k * ast)));
            chk($sformatf("d%0d c%0d B", d, c), 32'(bo[d]), 32'(8'(bs + k * bst)));
        end
        start[d] = 1'b0;
        chk($sformatf("d%0d n%0d SIG", d, n), 32'(sig[d]), 32'(es));
        chk($sformatf("d%0d n%0d N_GT", d, n), 32'(ngt[d]), gt);
        chk($sformatf("d%0d n%0d N_LT", d, n), 32'(nlt[d]), lt);
        chk($sformatf("d%0d n%0d N_EQ", d, n), 32'(neq[d]), eq);
    endtask

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        mode[0] = 0;
        mode[1] = 0;
        tick();
        tick();
        chk_idle(0, "reset d0");
        chk_idle(1, "reset d1");
        rst = 1'b0;
        tick();
        run(0, 8'd5, 8'd3, 8'd0, 8'd0, 1, 0, 1'b0);
        run(0, 8'd0, 8'd0, 8'd1, 8'd255, 4, 0, 1'b0);
        run(0, 8'h40, 8'h10, 8'd3, 8'd7, 3, 1, 1'b0);
        run(0, 8'h21, 8'h77, 8'd1, 8'd1, 0, 0, 1'b0);
        run(0, 8'd10, 8'd12, 8'd1, 8'd0, 4, 0, 1'b1);
        run(1, 8'd9, 8'd9, 8'd0, 8'd0, 2, 2, 1'b0);
        for (int r = 0; r < 8; r++)
            run(r % 2, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 6), $urandom_range(0, 2), r[2]);
        // abort a COUNT=4 run with RST asserted during cycle 4
        mode[0] = 0;
        a_seed = 8'd7; b_seed = 8'd2; a_step = 8'd1; b_step = 8'd0; count = 16'd4;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int c = 2; c <= 4; c++) tick();
        rst = 1'b1;
        tick();
        chk_idle(0, "abort");
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("abort idle c%0d DONE", c), 32'(done[0]), 0);
            chk($sformatf("abort idle c%0d BUSY", c), 32'(busy[0]), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
